logic_unit_pipe: RTL and testbench

LOGIC_UNIT_PIPE -- requirements
Module: logic_unit_pipe

---
 rtl/logic_unit_pkg.sv | 11 +
 rtl/logic_unit_pipe_bit_func.sv | 22 ++
 rtl/logic_unit_pipe.sv | 67 ++++++
 tb/tb_logic_unit_pipe.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_pkg.sv
// logic_unit_pkg: function-select enum and default widths shared by logic_unit_pipe and bit_func
package logic_unit_pkg;
  typedef enum logic [1:0] {
    MODE_GATE  = 2'd0,
    MODE_FADD  = 2'd1,
    MODE_NAND3 = 2'd2,
    MODE_PASS  = 2'd3
  } mode_e;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 16;
endpackage

// File: rtl/logic_unit_pipe_bit_func.sv
// bit_func: bitwise function unit; a, b, c, mode in -> x, y out (GATE, FADD, NAND3, PASS)
module bit_func
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  mode_e            mode,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y
);
  always_comb begin
    x = mode == MODE_GATE  ? (a | b) ^ ~c :
        mode == MODE_FADD  ? a ^ b ^ c :
        mode == MODE_NAND3 ? ~(a & b & c) : a;
    y = mode == MODE_GATE  ? a & b :
        mode == MODE_FADD  ? (a & b) | (a & c) | (b & c) :
        mode == MODE_NAND3 ? a | b | c : b;
  end
endmodule

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: 2-stage valid/ready bitwise logic pipe; in_valid/in_ready/a/b/c/mode in, out_valid/out_ready/x/y out, cnt_clr/txn_count handshake counter
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  mode_e            mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] txn_count
);
  logic             s1_valid, s2_valid, s1_load, s2_load;
  logic [WIDTH-1:0] s1_a, s1_b, s1_c, f_x, f_y;
  mode_e            s1_mode;
  assign s2_load   = !s2_valid || out_ready;
  assign s1_load   = !s1_valid || s2_load;
  assign in_ready  = s1_load;
  assign out_valid = s2_valid;
  bit_func #(.WIDTH(WIDTH)) u_func (
    .a(s1_a), .b(s1_b), .c(s1_c), .mode(s1_mode), .x(f_x), .y(f_y)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_c      <= '0;
      s1_mode   <= MODE_GATE;
      s2_valid  <= 1'b0;
      x         <= '0;
      y         <= '0;
      txn_count <= '0;
    end else begin
      if (s1_load) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_a    <= a;
          s1_b    <= b;
          s1_c    <= c;
          s1_mode <= mode;
        end
      end
      if (s2_load) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          x <= f_x;
          y <= f_y;
        end
      end
      if (cnt_clr)
        txn_count <= '0;
      else if (s2_valid && out_ready && txn_count != {CNT_W{1'b1}})
        txn_count <= txn_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: directed and randomized self-checking bench for logic_unit_pipe
module tb_logic_unit_pipe;
  import logic_unit_pkg::*;
  localparam int W = 8;
  localparam int CW = 4;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          iv = 1'b0, ordy = 1'b0, clr = 1'b0;
  logic [W-1:0]  ia = '0, ib = '0, ic = '0;
  mode_e         im = MODE_GATE;
  logic          in_ready, out_valid;
  logic [W-1:0]  x, y;
  logic [CW-1:0] txn_count;
  int            vectors = 0, miscompares = 0;
  int            in_hs = 0, out_hs = 0;
  int            cnt_m = 0;
  logic [2*W-1:0] q[$];
  logic          prev_stall = 1'b0;
  logic [W-1:0]  px, py;

  logic_unit_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(in_ready),
    .a(ia), .b(ib), .c(ic), .mode(im), .out_valid(out_valid),
    .out_ready(ordy), .x(x), .y(y), .cnt_clr(clr), .txn_count(txn_count)
  );

  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] ref_f(logic [W-1:0] a, logic [W-1:0] b, logic [W-1:0] c, mode_e m);
    case (m)
      MODE_GATE:  return {(a | b) ^ ~c, a & b};
      MODE_FADD:  return {a ^ b ^ c, (a & b) | (a & c) | (b & c)};
      MODE_NAND3: return {~(a & b & c), a | b | c};
      default:    return {a, b};
    endcase
  endfunction

  // one clock cycle: entered just after a negedge, returns at the next negedge
  task automatic cycle();
    logic ir_s, ov_s;
    logic [W-1:0] x_s, y_s;
    logic [2*W-1:0] e;
    #1;
    ir_s = in_ready; ov_s = out_valid; x_s = x; y_s = y;
    vectors++;
    if (txn_count !== CW'(cnt_m)) begin
      miscompares++;
      $display("FAIL txn_count: got %0d expected %0d", txn_count, cnt_m);
    end
    if (prev_stall) begin
      vectors++;
      if (ov_s !== 1'b1 || x_s !== px || y_s !== py) begin
        miscompares++;
        $display("FAIL stall_hold: got v=%b x=%h y=%h expected v=1 x=%h y=%h", ov_s, x_s, y_s, px, py);
      end
    end
    if (ov_s === 1'b1 && ordy) begin
      vectors++;
      out_hs++;
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL spurious_out: got x=%h y=%h expected no beat", x_s, y_s);
      end else begin
        e = q.pop_front();
        if ({x_s, y_s} !== e) begin
          miscompares++;
          $display("FAIL out_data: got x=%h y=%h expected x=%h y=%h", x_s, y_s, e[2*W-1:W], e[W-1:0]);
        end
      end
    end
    if (iv && ir_s === 1'b1) begin
      q.push_back(ref_f(ia, ib, ic, im));
      in_hs++;
    end
    if (clr) cnt_m = 0;
    else if (ov_s === 1'b1 && ordy && cnt_m != (1 << CW) - 1) cnt_m++;
    prev_stall = ov_s === 1'b1 && !ordy;
    px = x_s; py = y_s;
    @(negedge clk);
  endtask

  task automatic set_in(logic v, logic [W-1:0] a, logic [W-1:0] b, logic [W-1:0] c, mode_e m);
    iv = v; ia = a; ib = b; ic = c; im = m;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0 || x !== '0 || y !== '0 || txn_count !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got v=%b x=%h y=%h cnt=%0d expected all 0", out_valid, x, y, txn_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_after_reset: got %b expected 1", in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_vector(logic [W-1:0] a, logic [W-1:0] b, logic [W-1:0] c, mode_e m,
                             logic [W-1:0] ex, logic [W-1:0] ey);
    ordy = 1'b1;
    set_in(1'b1, a, b, c, m);
    cycle();
    set_in(1'b0, '0, '0, '0, MODE_GATE);
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL latency_early: got out_valid=%b expected 0", out_valid);
    end
    cycle();
    #1;
    vectors++;
    if (out_valid !== 1'b1 || x !== ex || y !== ey) begin
      miscompares++;
      $display("FAIL vector_m%0d: got v=%b x=%h y=%h expected v=1 x=%h y=%h", m, out_valid, x, y, ex, ey);
    end
    cycle();
  endtask

  task automatic test_stall();
    logic [W-1:0] av[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    int idx = 0;
    int acc;
    ordy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      acc = in_hs;
      set_in(idx < 4, av[idx % 4], 8'h5A, 8'hC3, MODE_FADD);
      cycle();
      if (in_hs != acc) idx++;
    end
    vectors++;
    if (idx !== 2) begin
      miscompares++;
      $display("FAIL stall_accept: got %0d beats accepted expected 2", idx);
    end
    ordy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      acc = in_hs;
      set_in(idx < 4, av[idx % 4], 8'h5A, 8'hC3, MODE_FADD);
      cycle();
      if (in_hs != acc) idx++;
    end
    set_in(1'b0, '0, '0, '0, MODE_GATE);
    vectors++;
    if (idx !== 4 || q.size() !== 0) begin
      miscompares++;
      $display("FAIL stall_drain: got accepted=%0d pending=%0d expected 4 and 0", idx, q.size());
    end
  endtask

  task automatic test_count();
    ordy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      set_in(1'b1, W'(i), W'(i * 3), W'(i * 7), MODE_PASS);
      cycle();
    end
    set_in(1'b0, '0, '0, '0, MODE_GATE);
    cycle();
    cycle();
    vectors++;
    if (txn_count !== 4'd15) begin
      miscompares++;
      $display("FAIL count_saturate: got %0d expected 15", txn_count);
    end
    set_in(1'b1, 8'hA5, 8'h5A, 8'h00, MODE_PASS);
    cycle();
    set_in(1'b0, '0, '0, '0, MODE_GATE);
    cycle();
    clr = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL clr_setup: got out_valid=%b expected 1", out_valid);
    end
    cycle();
    clr = 1'b0;
    #1;
    vectors++;
    if (txn_count !== 4'd0) begin
      miscompares++;
      $display("FAIL count_clear: got %0d expected 0", txn_count);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    ordy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 8'hE7, 8'h7E, 8'h99, MODE_NAND3);
      cycle();
    end
    set_in(1'b0, '0, '0, '0, MODE_GATE);
    rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || x !== '0 || y !== '0 || txn_count !== '0) begin
      miscompares++;
      $display("FAIL async_reset: got v=%b x=%h y=%h cnt=%0d expected all 0", out_valid, x, y, txn_count);
    end
    q.delete();
    cnt_m = 0;
    prev_stall = 1'b0;
    in_hs = 0;
    out_hs = 0;
    @(negedge clk);
    rst_n = 1'b1;
    ordy = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL stale_after_reset: got v=%b rdy=%b expected v=0 rdy=1", out_valid, in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int i = 0; i < 10000; i++) begin
      ordy = 1'($urandom_range(0, 1));
      set_in(1'($urandom_range(0, 1)), W'($urandom), W'($urandom), W'($urandom), mode_e'($urandom_range(0, 3)));
      cycle();
    end
    set_in(1'b0, '0, '0, '0, MODE_GATE);
    ordy = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    vectors++;
    if (q.size() !== 0 || out_valid !== 1'b0 || in_hs !== out_hs) begin
      miscompares++;
      $display("FAIL random_drain: got pending=%0d v=%b in=%0d out=%0d expected 0 0 equal", q.size(), out_valid, in_hs, out_hs);
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_vector(8'hF0, 8'hCC, 8'hAA, MODE_GATE,  8'hA9, 8'hC0);
    test_vector(8'hFF, 8'h0F, 8'h01, MODE_FADD,  8'hF1, 8'h0F);
    test_vector(8'hF0, 8'h3C, 8'hFF, MODE_NAND3, 8'hCF, 8'hFF);
    test_vector(8'h96, 8'h3B, 8'hFF, MODE_PASS,  8'h96, 8'h3B);
    test_stall();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
